roce_non_roce_arbiter: RTL and testbench
========================================

# roce_non_roce_arbiter

Packet-atomic round-robin arbiter that merges two AXI4-Stream packet sources, the RoCEv2 stream and the non-RoCEv2 stream, onto one egress AXI4-Stream in the `axis_aclk` domain. It sits downstream of packet classification wherever both classes must share a single consumer, such as a common DMA/C2H path or a loopback port. Once a source is granted, the grant holds for the whole packet, and the packet is forwarded without interleaving. The block also keeps per-source packet counters for debug.

## Interface
Parameters:
- AXIS_DATA_WIDTH, 512, tdata width
- AXIS_KEEP_WIDTH, 64, tkeep width
- AXIS_USER_WIDTH, 16, tuser_size width (packet length in bytes)
- CNT_WIDTH, 32, width of each packet counter

Ports:
- axis_aclk  in  1  the only clock
- axis_rstn  in  1  asynchronous, active-low reset
- s_axis_roce_tvalid / tdata / tkeep / tuser_size / tlast  in  1 / AXIS_DATA_WIDTH / AXIS_KEEP_WIDTH / AXIS_USER_WIDTH / 1  RoCE source
- s_axis_roce_tready  out  1  RoCE source ready
- s_axis_non_roce_tvalid / tdata / tkeep / tuser_size / tlast  in  same widths  non-RoCE source
- s_axis_non_roce_tready  out  1  non-RoCE source ready
- m_axis_tvalid / tdata / tkeep / tuser_size / tlast  out  same widths  merged egress
- m_axis_tuser_src  out  1  source of the current beat: 1 = RoCE, 0 = non-RoCE
- m_axis_tready  in  1  egress ready
- cnt_clear  in  1  synchronous clear of both counters
- roce_pkt_cnt  out  CNT_WIDTH  RoCE packets forwarded
- non_roce_pkt_cnt  out  CNT_WIDTH  non-RoCE packets forwarded

## Operation
- The FSM has three states: IDLE, GNT_ROCE and GNT_NON_ROCE.
- A `last_grant` register records the previously served source. Its reset value is non-RoCE, so RoCE wins the first tie.
- Transitions out of IDLE:
  - Only one source has tvalid=1: go to that source's grant state.
  - Both sources have tvalid=1: go to the grant state of the source that is not `last_grant`.
  - Neither has tvalid: stay in IDLE.
- On entering a grant state, update `last_grant` to the granted source.
- Behaviour in a grant state:
  - Pass-through is combinational. m_axis_tvalid, tdata, tkeep, tuser_size and tlast come from the granted source.
  - The granted source's tready equals m_axis_tready. The other source's tready is 0.
  - m_axis_tuser_src identifies the granted source.
- Leave the grant state and return to IDLE on the handshake (m_axis_tvalid & m_axis_tready) of the beat with tlast=1.
- The grant never moves mid-packet. A source that deasserts tvalid mid-packet stalls the egress, and the grant is held.
- While in IDLE:
  - Both s_*_tready are 0.
  - m_axis_tvalid is 0.
  - m_axis_tdata, tkeep, tuser_size, tlast and tuser_src are driven to 0.
- Counters:
  - On the tlast handshake, increment the granted source's counter by 1.
  - Counters saturate at 2^CNT_WIDTH-1 and do not wrap.
  - cnt_clear=1 sets both counters to 0. If clear and increment happen in the same cycle, clear wins and the result is 0.
- A single-beat packet (tlast on the first beat) is legal. Its one handshake both counts the packet and returns the FSM to IDLE.

## Timing
- Reset (axis_rstn=0, asynchronous):
  - State goes to IDLE and `last_grant` to non-RoCE.
  - Both counters go to 0.
  - All outputs go to 0 immediately: m_axis_*, both s_*_tready, and both counters.
- Reset mid-packet discards the rest of the grant. After reset the upstream packet remainder is treated as a new packet; the bench must not rely on recovery.
- Arbitration latency is 1 cycle. A tvalid rising in IDLE at cycle N gives m_axis_tvalid=1 at cycle N+1.
- Within a packet there is no added latency and no bubble, so throughput is 1 beat per cycle when m_axis_tready=1.
- Between packets there is exactly one IDLE cycle after each tlast handshake. The maximum egress rate for n-beat packets is n/(n+1).
- Counter update: the counter value reflects a tlast handshake at cycle N from cycle N+1.
- AXIS rules are held on egress:
  - m_axis_tvalid is never withdrawn by the arbiter without a handshake, provided the granted source obeys AXIS.
  - Payload is unchanged while m_axis_tvalid=1 and m_axis_tready=0.

## Test plan
- **RoCE only.** One 4-beat RoCE packet with tuser_size=200 and m_axis_tready=1.
  - Egress shows 4 consecutive beats starting 1 cycle after the first tvalid, with tuser_src=1 and tlast on beat 4.
  - roce_pkt_cnt=1 and non_roce_pkt_cnt=0.
- **Simultaneous requests.** Both sources present 3-beat packets at cycle 0 just after reset.
  - The RoCE packet occupies cycles 1-3, IDLE at cycle 4, the non-RoCE packet occupies cycles 5-7.
  - Both counters equal 1.
- **Fairness.** Both sources present 10 back-to-back 1-beat packets continuously.
  - Egress strictly alternates RoCE, non-RoCE, ... with each packet followed by one IDLE cycle.
  - Final counts are 10/10.
- **Backpressure and source stall.** m_axis_tready toggles every cycle, and the granted source drops tvalid for 2 cycles mid-packet.
  - No beat is lost or duplicated, and the grant stays on the same source.
  - The other source's tready stays 0 throughout.
- **Counter edges.** Force CNT_WIDTH=4 and send 17 RoCE packets.
  - roce_pkt_cnt stops at 15.
  - Assert cnt_clear on the cycle of an 18th tlast handshake: count becomes 0.
- **Reset mid-packet.** Assert axis_rstn=0 at beat 2 of a 5-beat packet.
  - All outputs go to 0 asynchronously, and the counters read 0.
  - After release, a new non-RoCE packet is granted normally.

Source files
------------

// File: rtl/roce_non_roce_arbiter_if.sv
// AXI4-Stream packet bus carrying tdata/tkeep/tuser_size/tlast.
// The master drives the payload and tvalid; the slave drives tready.
interface roce_non_roce_arbiter_if #(
  parameter int DATA_W = 512,
  parameter int KEEP_W = 64,
  parameter int USER_W = 16
);
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic [USER_W-1:0] tuser_size;
  logic              tlast;

  modport master (output tvalid, tdata, tkeep, tuser_size, tlast, input tready);
  modport slave  (input tvalid, tdata, tkeep, tuser_size, tlast, output tready);
endinterface

// File: rtl/roce_non_roce_arbiter.sv
// Packet-atomic round-robin merge of RoCE and non-RoCE AXIS sources, with saturating per-source packet counters.
// Latency: 1-cycle grant from IDLE, then combinational pass-through; egress tready feeds only the granted source.
module roce_non_roce_arbiter #(
  parameter int AXIS_DATA_WIDTH = 512,
  parameter int AXIS_KEEP_WIDTH = 64,
  parameter int AXIS_USER_WIDTH = 16,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                        axis_aclk,
  input  logic                        axis_rstn,
  roce_non_roce_arbiter_if.slave      s_axis_roce,
  roce_non_roce_arbiter_if.slave      s_axis_non_roce,
  roce_non_roce_arbiter_if.master     m_axis,
  output logic                        m_axis_tuser_src,
  input  logic                        cnt_clear,
  output logic [CNT_WIDTH-1:0]        roce_pkt_cnt,
  output logic [CNT_WIDTH-1:0]        non_roce_pkt_cnt
);

  typedef enum logic [1:0] {IDLE, GNT_ROCE, GNT_NON_ROCE} state_e;

  state_e               state_q, state_d;
  logic                 last_grant_q, last_grant_d;  // 1 = RoCE served last
  logic [CNT_WIDTH-1:0] roce_cnt_q, roce_cnt_d;
  logic [CNT_WIDTH-1:0] non_cnt_q, non_cnt_d;

  logic                       mux_vld;
  logic [AXIS_DATA_WIDTH-1:0] mux_dat;
  logic [AXIS_KEEP_WIDTH-1:0] mux_keep;
  logic [AXIS_USER_WIDTH-1:0] mux_size;
  logic                       mux_last;
  logic                       mux_src;
  logic                       roce_rdy, non_rdy;
  logic                       roce_done, non_done;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mux_vld      = 1'b0;
    mux_dat      = '0;
    mux_keep     = '0;
    mux_size     = '0;
    mux_last     = 1'b0;
    mux_src      = 1'b0;
    roce_rdy     = 1'b0;
    non_rdy      = 1'b0;
    roce_done    = 1'b0;
    non_done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        // On a tie, serve whichever source did not go last.
        if (s_axis_roce.tvalid && (!s_axis_non_roce.tvalid || !last_grant_q)) begin
          state_d      = GNT_ROCE;
          last_grant_d = 1'b1;
        end else if (s_axis_non_roce.tvalid) begin
          state_d      = GNT_NON_ROCE;
          last_grant_d = 1'b0;
        end
      end
      GNT_ROCE: begin
        mux_vld   = s_axis_roce.tvalid;
        mux_dat   = s_axis_roce.tdata;
        mux_keep  = s_axis_roce.tkeep;
        mux_size  = s_axis_roce.tuser_size;
        mux_last  = s_axis_roce.tlast;
        mux_src   = 1'b1;
        roce_rdy  = m_axis.tready;
        roce_done = s_axis_roce.tvalid && m_axis.tready && s_axis_roce.tlast;
        if (roce_done) state_d = IDLE;
      end
      GNT_NON_ROCE: begin
        mux_vld  = s_axis_non_roce.tvalid;
        mux_dat  = s_axis_non_roce.tdata;
        mux_keep = s_axis_non_roce.tkeep;
        mux_size = s_axis_non_roce.tuser_size;
        mux_last = s_axis_non_roce.tlast;
        non_rdy  = m_axis.tready;
        non_done = s_axis_non_roce.tvalid && m_axis.tready && s_axis_non_roce.tlast;
        if (non_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    roce_cnt_d = roce_cnt_q;
    non_cnt_d  = non_cnt_q;
    if (cnt_clear) begin
      roce_cnt_d = '0;
      non_cnt_d  = '0;
    end else begin
      if (roce_done && (roce_cnt_q != '1)) roce_cnt_d = roce_cnt_q + CNT_WIDTH'(1);
      if (non_done && (non_cnt_q != '1))   non_cnt_d  = non_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge axis_aclk or negedge axis_rstn) begin
    if (!axis_rstn) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b0;
      roce_cnt_q   <= '0;
      non_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      roce_cnt_q   <= roce_cnt_d;
      non_cnt_q    <= non_cnt_d;
    end
  end

  assign m_axis.tvalid          = mux_vld;
  assign m_axis.tdata           = mux_dat;
  assign m_axis.tkeep           = mux_keep;
  assign m_axis.tuser_size      = mux_size;
  assign m_axis.tlast           = mux_last;
  assign m_axis_tuser_src       = mux_src;
  assign s_axis_roce.tready     = roce_rdy;
  assign s_axis_non_roce.tready = non_rdy;
  assign roce_pkt_cnt           = roce_cnt_q;
  assign non_roce_pkt_cnt       = non_cnt_q;

endmodule

// File: tb/tb_roce_non_roce_arbiter.sv
// Randomized and directed bench for roce_non_roce_arbiter against an in-bench packet-level model.
module tb_roce_non_roce_arbiter;
  localparam int DW = 64;
  localparam int KW = 8;
  localparam int UW = 16;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic axis_aclk = 1'b0;
  logic axis_rstn = 1'b0;
  logic cnt_clear;
  logic m_axis_tuser_src;
  logic [CW-1:0] roce_pkt_cnt, non_roce_pkt_cnt;

  always #5 axis_aclk = ~axis_aclk;

  roce_non_roce_arbiter_if #(.DATA_W(DW), .KEEP_W(KW), .USER_W(UW)) roce_if ();
  roce_non_roce_arbiter_if #(.DATA_W(DW), .KEEP_W(KW), .USER_W(UW)) non_if ();
  roce_non_roce_arbiter_if #(.DATA_W(DW), .KEEP_W(KW), .USER_W(UW)) m_if ();

  roce_non_roce_arbiter #(
    .AXIS_DATA_WIDTH(DW), .AXIS_KEEP_WIDTH(KW), .AXIS_USER_WIDTH(UW), .CNT_WIDTH(CW)
  ) dut (
    .axis_aclk       (axis_aclk),
    .axis_rstn       (axis_rstn),
    .s_axis_roce     (roce_if),
    .s_axis_non_roce (non_if),
    .m_axis          (m_if),
    .m_axis_tuser_src(m_axis_tuser_src),
    .cnt_clear       (cnt_clear),
    .roce_pkt_cnt    (roce_pkt_cnt),
    .non_roce_pkt_cnt(non_roce_pkt_cnt)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] size;
    logic          last;
  } beat_t;

  beat_t r_q[$], n_q[$], r_exp[$], n_exp[$];
  bit    r_vld, n_vld;
  int    r_stall, n_stall, r_stall_at, r_done_beats;
  int    gap_pct, rdy_mode, clear_pct;
  bit    clear_on_hs;
  int    owner;        // 0 none, 1 RoCE, 2 non-RoCE
  bit    last_roce;
  int    exp_rc, exp_nc;
  int    cyc;
  int    trace[$];     // per cycle: 0 idle, 1 RoCE beat, 2 non-RoCE beat, +4 when tlast
  int    hs_log[$];    // source of every egress handshake, 1 = RoCE
  bit    prev_stall;
  beat_t prev_beat;
  int    n_checks = 0;
  int    n_fail = 0;

  int e_t1[6] = '{0, 1, 1, 1, 5, 0};
  int e_t2[9] = '{0, 1, 1, 5, 0, 2, 2, 6, 0};
  int e_t6[3] = '{0, 6, 0};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int tr(input int i);
    return (i < trace.size()) ? trace[i] : -1;
  endfunction

  task automatic model_reset();
    owner = 0; last_roce = 0; exp_rc = 0; exp_nc = 0;
    r_vld = 0; n_vld = 0; r_stall = 0; n_stall = 0; r_stall_at = -1; r_done_beats = 0;
    gap_pct = 0; rdy_mode = 0; clear_pct = 0; clear_on_hs = 0; prev_stall = 0;
    r_q.delete(); n_q.delete(); r_exp.delete(); n_exp.delete();
    trace.delete(); hs_log.delete();
  endtask

  task automatic push_pkt(input bit roce, input int nb, input int sz);
    for (int i = 0; i < nb; i++) begin
      beat_t b;
      b.data = {$urandom, $urandom};
      b.keep = (i == nb - 1) ? KW'($urandom_range(1, 255)) : '1;
      b.size = UW'(sz);
      b.last = (i == nb - 1);
      if (roce) begin r_q.push_back(b); r_exp.push_back(b); end
      else      begin n_q.push_back(b); n_exp.push_back(b); end
    end
  endtask

  task automatic drive();
    if (!r_vld && r_q.size() > 0) begin
      if (r_stall > 0) r_stall--;
      else if ($urandom_range(99) >= gap_pct) r_vld = 1;
    end
    if (!n_vld && n_q.size() > 0) begin
      if (n_stall > 0) n_stall--;
      else if ($urandom_range(99) >= gap_pct) n_vld = 1;
    end
    roce_if.tvalid = r_vld;
    if (r_vld) {roce_if.tdata, roce_if.tkeep, roce_if.tuser_size, roce_if.tlast} = r_q[0];
    else {roce_if.tdata, roce_if.tkeep, roce_if.tuser_size, roce_if.tlast} = {$urandom, $urandom, 25'd0};
    non_if.tvalid = n_vld;
    if (n_vld) {non_if.tdata, non_if.tkeep, non_if.tuser_size, non_if.tlast} = n_q[0];
    else {non_if.tdata, non_if.tkeep, non_if.tuser_size, non_if.tlast} = {$urandom, $urandom, 25'd0};
    case (rdy_mode)
      0:       m_if.tready = 1'b1;
      1:       m_if.tready = (cyc % 2 == 0);
      default: m_if.tready = 1'($urandom_range(1));
    endcase
    cnt_clear = (clear_on_hs && owner == 1 && r_vld && r_q[0].last && m_if.tready)
                || ($urandom_range(99) < clear_pct);
  endtask

  task automatic check_cycle();
    beat_t rb, nb, eb, ab;
    bit    exp_v, exp_src, exp_rr, exp_nr, hs;
    rb = {roce_if.tdata, roce_if.tkeep, roce_if.tuser_size, roce_if.tlast};
    nb = {non_if.tdata, non_if.tkeep, non_if.tuser_size, non_if.tlast};
    ab = {m_if.tdata, m_if.tkeep, m_if.tuser_size, m_if.tlast};
    exp_v = 0; exp_src = 0; exp_rr = 0; exp_nr = 0; eb = '0;
    if (owner == 1) begin exp_v = roce_if.tvalid; eb = rb; exp_src = 1; exp_rr = m_if.tready; end
    if (owner == 2) begin exp_v = non_if.tvalid;  eb = nb; exp_nr = m_if.tready; end
    chk("m_tvalid", m_if.tvalid, exp_v);
    chk("m_payload", ab, eb);
    chk("m_tuser_src", m_axis_tuser_src, exp_src);
    chk("roce_tready", roce_if.tready, exp_rr);
    chk("non_roce_tready", non_if.tready, exp_nr);
    chk("roce_pkt_cnt", roce_pkt_cnt, exp_rc);
    chk("non_roce_pkt_cnt", non_roce_pkt_cnt, exp_nc);
    if (prev_stall) begin
      chk("hold_tvalid", m_if.tvalid, 1);
      chk("hold_payload", ab, prev_beat);
    end
    prev_stall = m_if.tvalid && !m_if.tready;
    prev_beat  = ab;
    hs = exp_v && m_if.tready;
    trace.push_back(exp_v ? ((owner == 1 ? 1 : 2) + (eb.last ? 4 : 0)) : 0);
    if (hs) begin
      hs_log.push_back(owner == 1 ? 1 : 0);
      if (owner == 1) begin
        if (r_exp.size() == 0) chk("sb_roce_extra", 1, 0);
        else chk("sb_roce", ab, r_exp.pop_front());
        void'(r_q.pop_front()); r_vld = 0; r_done_beats++;
        if (r_done_beats == r_stall_at) r_stall = 2;
      end else begin
        if (n_exp.size() == 0) chk("sb_non_extra", 1, 0);
        else chk("sb_non", ab, n_exp.pop_front());
        void'(n_q.pop_front()); n_vld = 0;
      end
    end
    if (cnt_clear) begin
      exp_rc = 0; exp_nc = 0;
    end else if (hs && eb.last) begin
      if (owner == 1) exp_rc = (exp_rc == CMAX) ? CMAX : exp_rc + 1;
      else            exp_nc = (exp_nc == CMAX) ? CMAX : exp_nc + 1;
    end
    if (owner == 0) begin
      if (roce_if.tvalid && (!non_if.tvalid || !last_roce)) begin owner = 1; last_roce = 1; end
      else if (non_if.tvalid) begin owner = 2; last_roce = 0; end
    end else if (hs && eb.last) begin
      owner = 0;
    end
    cyc++;
  endtask

  task automatic step();
    @(posedge axis_aclk); #1;
    drive();
    @(negedge axis_aclk);
    check_cycle();
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((r_q.size() > 0 || n_q.size() > 0 || owner != 0) && k < budget) begin
      step();
      k++;
    end
    if (k >= budget) chk("drain_timeout", k, 0);
    step();
  endtask

  task automatic do_reset();
    axis_rstn = 1'b0;
    roce_if.tvalid = 0; non_if.tvalid = 0; m_if.tready = 0; cnt_clear = 0;
    model_reset();
    #1;
    chk("rst_m_tvalid", m_if.tvalid, 0);
    chk("rst_roce_tready", roce_if.tready, 0);
    chk("rst_non_tready", non_if.tready, 0);
    chk("rst_roce_cnt", roce_pkt_cnt, 0);
    chk("rst_non_cnt", non_roce_pkt_cnt, 0);
    repeat (2) @(posedge axis_aclk);
    @(negedge axis_aclk);
    axis_rstn = 1'b1;
    cyc = 0;
  endtask

  initial begin
    cyc = 0;
    // RoCE only: 4 beats right after the first tvalid cycle
    do_reset();
    push_pkt(1, 4, 200);
    drain(50);
    for (int i = 0; i < 6; i++) chk($sformatf("t1_trace%0d", i), tr(i), e_t1[i]);
    chk("t1_roce_cnt", roce_pkt_cnt, 1);
    chk("t1_non_cnt", non_roce_pkt_cnt, 0);

    // Simultaneous requests: RoCE wins the first tie
    do_reset();
    push_pkt(1, 3, 64);
    push_pkt(0, 3, 96);
    drain(50);
    for (int i = 0; i < 9; i++) chk($sformatf("t2_trace%0d", i), tr(i), e_t2[i]);
    chk("t2_roce_cnt", roce_pkt_cnt, 1);
    chk("t2_non_cnt", non_roce_pkt_cnt, 1);

    // Fairness: strict alternation with one idle cycle between packets
    do_reset();
    for (int i = 0; i < 10; i++) begin push_pkt(1, 1, 60 + i); push_pkt(0, 1, 90 + i); end
    drain(100);
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("t3_pkt%0d", k), tr(1 + 2 * k), (k % 2 == 0) ? 5 : 6);
      chk($sformatf("t3_gap%0d", k), tr(2 + 2 * k), 0);
    end
    chk("t3_roce_cnt", roce_pkt_cnt, 10);
    chk("t3_non_cnt", non_roce_pkt_cnt, 10);

    // Backpressure toggling plus a 2-cycle source stall mid-packet
    do_reset();
    rdy_mode = 1;
    r_stall_at = 2;
    push_pkt(1, 6, 300);
    push_pkt(0, 3, 120);
    drain(100);
    chk("t4_hs_count", hs_log.size(), 9);
    for (int i = 0; i < 9; i++) chk($sformatf("t4_hs_src%0d", i), (i < hs_log.size()) ? hs_log[i] : -1, (i < 6) ? 1 : 0);
    chk("t4_roce_left", r_exp.size(), 0);
    chk("t4_non_left", n_exp.size(), 0);

    // Counter saturation, then clear winning over a simultaneous increment
    do_reset();
    for (int i = 0; i < 17; i++) push_pkt(1, 1, 64);
    drain(200);
    chk("t5_sat", roce_pkt_cnt, 15);
    chk("t5_non", non_roce_pkt_cnt, 0);
    clear_on_hs = 1;
    push_pkt(1, 1, 64);
    drain(20);
    clear_on_hs = 0;
    chk("t5_clear", roce_pkt_cnt, 0);

    // Reset in the middle of a 5-beat RoCE packet
    do_reset();
    push_pkt(0, 1, 80);
    drain(20);
    chk("t6_non_before", non_roce_pkt_cnt, 1);
    push_pkt(1, 5, 400);
    for (int k = 0; k < 20 && r_done_beats < 1; k++) step();
    @(posedge axis_aclk); #1;
    drive();
    #1;
    chk("t6_pre_tvalid", m_if.tvalid, 1);
    axis_rstn = 1'b0;
    #1;
    chk("t6_rst_tvalid", m_if.tvalid, 0);
    chk("t6_rst_payload", {m_if.tdata, m_if.tkeep, m_if.tuser_size, m_if.tlast}, 0);
    chk("t6_rst_src", m_axis_tuser_src, 0);
    chk("t6_rst_roce_rdy", roce_if.tready, 0);
    chk("t6_rst_non_rdy", non_if.tready, 0);
    chk("t6_rst_non_cnt", non_roce_pkt_cnt, 0);
    do_reset();
    push_pkt(0, 1, 77);
    drain(20);
    for (int i = 0; i < 3; i++) chk($sformatf("t6_trace%0d", i), tr(i), e_t6[i]);
    chk("t6_non_after", non_roce_pkt_cnt, 1);

    // Randomized traffic, gaps, backpressure and occasional clears
    do_reset();
    gap_pct = 30;
    rdy_mode = 2;
    clear_pct = 3;
    for (int i = 0; i < 40; i++) push_pkt(1'($urandom_range(1)), $urandom_range(1, 5), $urandom_range(1, 1500));
    drain(3000);
    chk("t7_roce_left", r_exp.size(), 0);
    chk("t7_non_left", n_exp.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
